arm_exec_unit: RTL and testbench
================================

# arm_exec_unit

Execute-stage arithmetic block for the single-cycle ARM datapath. Bundles the PC+4/PC+8 incrementers, the immediate extender and a 16-operation ARM ALU with NZCV generation. Holds the only state: a flag register that supplies the stored carry to ADC/SBC/RSC. Sits between the register file/source muxes and the result mux; the condition-check logic consumes its flags.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- pc  in  32  current PC
- pc_plus4  out  32  pc + 4, modulo 2^32
- pc_plus8  out  32  pc + 8, modulo 2^32
- instr_imm  in  24  Instr[23:0]
- imm_src  in  2  extension selector
- ext_imm  out  32  extended immediate
- src_a  in  32  ALU operand A
- src_b  in  32  ALU operand B
- alu_control  in  4  ALU operation code
- flag_write  in  1  capture alu_flags into the flag register
- alu_result  out  32  ALU result
- alu_flags  out  4  combinational {N,Z,C,V} of the current operation
- stored_flags  out  4  registered {N,Z,C,V}

## Operation
- Adders: pc_plus4 = pc + 4; pc_plus8 = pc_plus4 + 4; carry-out discarded (0xFFFFFFFC → 0x00000000, 0x00000004).
- Extend (imm_src): 00 = data-processing, zero-extend instr_imm[7:0]; 01 = load/store, zero-extend instr_imm[11:0]; 10 = branch, sign-extend instr_imm[23:0] then shift left 2; 11 = 32'h0.
- ALU opcodes (alu_control): 0 AND, 1 EOR, 2 SUB (A−B), 3 RSB (B−A), 4 ADD, 5 ADC (A+B+Cs), 6 SBC (A−B−!Cs), 7 RSC (B−A−!Cs), 8 TST (AND), 9 TEQ (EOR), A CMP (SUB), B CMN (ADD), C ORR, D MOV (B), E BIC (A & ~B), F MVN (~B). Cs = stored_flags C bit.
- Subtraction implemented as X + ~Y + cin (cin = 1 for SUB/RSB/CMP, Cs for SBC/RSC); C = adder carry-out (1 means no borrow).
- Flags: N = result[31]; Z = (result == 0); arithmetic ops: C = carry-out, V = signed overflow (operands same sign as adder inputs, result sign differs). Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C and V pass through stored_flags C and V unchanged.
- Compare ops (8–B) still drive alu_result; write-back suppression is outside this block.

## Timing
- Everything except the flag register is purely combinational, zero latency.
- Flag register: on rising clk, reset==0 → stored_flags = 4'b0000; else if flag_write → stored_flags = alu_flags; else hold.
- Reset dominates flag_write in the same cycle. Reset mid-sequence clears carry, so the next ADC behaves as ADD.
- An ADC in the cycle after a flag-writing ADD uses the new carry; an ADC in the same cycle uses the old one (no forwarding).

## Configuration
- ROT_IMM_EN defined: imm_src 00 produces ARM rotated immediate, {24'b0, instr_imm[7:0]} rotated right by 2 × instr_imm[11:8].
- Undefined: imm_src 00 is plain zero-extension of instr_imm[7:0], instr_imm[11:8] ignored.

## Structure
- Shared package exec_pkg: alu_op_e enum (16 opcodes above), imm_src_e enum (DP, MEM, BR, ZERO), flag bit index constants (N=3, Z=2, C=1, V=0).
- One sub-module: alu_core (combinational ALU + flag generation); incrementers, extender and flag register stay in the top.

## Test plan
- Reset low one edge with flag_write=1 → stored_flags=0000; pc=0x100 → pc_plus4=0x104, pc_plus8=0x108.
- ADD 0xFFFFFFFF + 0x1 → result 0, alu_flags 0110; SUB 5−5 → 0, flags 0110; ADD 0x7FFFFFFF + 1 → 0x80000000, flags 1001.
- ADD 0xFFFFFFFF + 1 with flag_write, next cycle ADC 2 + 3 → 6; after reset, ADC 2 + 3 → 5.
- SBC 10 − 3 with Cs=0 → 6; RSB A=3, B=10 → 7, C=1.
- Extend: imm_src=10, instr_imm=0xFFFFFE → 0xFFFFFFF8; imm_src=01, 0x000ABC → 0x00000ABC; imm_src=11 → 0.
- ROT_IMM_EN: imm_src=00, instr_imm=0x0004FF → 0xFF000000; without macro → 0x000000FF.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the ARM execute-stage arithmetic block:
// ALU opcodes, immediate-source selectors and flag bit positions.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_EOR = 4'h1,
        ALU_SUB = 4'h2,
        ALU_RSB = 4'h3,
        ALU_ADD = 4'h4,
        ALU_ADC = 4'h5,
        ALU_SBC = 4'h6,
        ALU_RSC = 4'h7,
        ALU_TST = 4'h8,
        ALU_TEQ = 4'h9,
        ALU_CMP = 4'hA,
        ALU_CMN = 4'hB,
        ALU_ORR = 4'hC,
        ALU_MOV = 4'hD,
        ALU_BIC = 4'hE,
        ALU_MVN = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_DP   = 2'b00,
        IMM_MEM  = 2'b01,
        IMM_BR   = 2'b10,
        IMM_ZERO = 2'b11
    } imm_src_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Logical operations leave C and V untouched (they pass the stored bits through).
    function automatic logic is_logical_op(input alu_op_e op);
        case (op)
            ALU_AND, ALU_EOR, ALU_TST, ALU_TEQ,
            ALU_ORR, ALU_MOV, ALU_BIC, ALU_MVN: is_logical_op = 1'b1;
            default:                            is_logical_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 16-operation ARM ALU with NZCV generation.
// Every arithmetic op runs through one 33-bit adder (x + y + cin);
// subtraction is x + ~y + cin so the carry-out reads as "no borrow".
module alu_core
    import exec_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  alu_control,
    input  logic        carry_in,
    input  logic        overflow_in,
    output logic [31:0] alu_result,
    output logic [3:0]  alu_flags
);

    alu_op_e     op;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [32:0] add_sum;
    logic        add_v;

    assign op = alu_op_e'(alu_control);

    // Select adder operands: operand order and inversion encode SUB/RSB/SBC/RSC.
    always_comb begin
        add_x   = src_a;
        add_y   = src_b;
        add_cin = 1'b0;
        case (op)
            ALU_SUB, ALU_CMP: begin
                add_x   = src_a;
                add_y   = ~src_b;
                add_cin = 1'b1;
            end
            ALU_RSB: begin
                add_x   = src_b;
                add_y   = ~src_a;
                add_cin = 1'b1;
            end
            ALU_ADC: begin
                add_x   = src_a;
                add_y   = src_b;
                add_cin = carry_in;
            end
            ALU_SBC: begin
                add_x   = src_a;
                add_y   = ~src_b;
                add_cin = carry_in;
            end
            ALU_RSC: begin
                add_x   = src_b;
                add_y   = ~src_a;
                add_cin = carry_in;
            end
            default: begin
                add_x   = src_a;
                add_y   = src_b;
                add_cin = 1'b0;
            end
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_cin};
    // Signed overflow: adder inputs agree in sign but the sum does not.
    assign add_v   = (add_x[31] == add_y[31]) && (add_sum[31] != add_x[31]);

    // Result mux and flag generation.
    always_comb begin
        alu_result = add_sum[31:0];
        case (op)
            ALU_AND, ALU_TST: alu_result = src_a & src_b;
            ALU_EOR, ALU_TEQ: alu_result = src_a ^ src_b;
            ALU_ORR:          alu_result = src_a | src_b;
            ALU_MOV:          alu_result = src_b;
            ALU_BIC:          alu_result = src_a & ~src_b;
            ALU_MVN:          alu_result = ~src_b;
            default:          alu_result = add_sum[31:0];
        endcase

        alu_flags         = 4'b0000;
        alu_flags[FLAG_N] = alu_result[31];
        alu_flags[FLAG_Z] = (alu_result == 32'h0);
        if (is_logical_op(op)) begin
            alu_flags[FLAG_C] = carry_in;
            alu_flags[FLAG_V] = overflow_in;
        end else begin
            alu_flags[FLAG_C] = add_sum[32];
            alu_flags[FLAG_V] = add_v;
        end
    end

endmodule

// File: rtl/arm_exec_unit.sv
// Execute-stage arithmetic block: PC+4/PC+8 incrementers, immediate
// extender, ALU (alu_core) and the NZCV flag register.
// Optional build macro ROT_IMM_EN: data-processing immediates are produced
// as ARM rotated immediates instead of a plain 8-bit zero-extension.
module arm_exec_unit
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_plus8,
    input  logic [23:0] instr_imm,
    input  logic [1:0]  imm_src,
    output logic [31:0] ext_imm,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  alu_control,
    input  logic        flag_write,
    output logic [31:0] alu_result,
    output logic [3:0]  alu_flags,
    output logic [3:0]  stored_flags
);

    logic [31:0] dp_imm;

    assign pc_plus4 = pc + 32'd4;
    assign pc_plus8 = pc_plus4 + 32'd4;

`ifdef ROT_IMM_EN
    logic [4:0]  rot_amt;
    logic [63:0] rot_pair;

    // Rotate right by 2*rot: shift a doubled copy so wrapped bits fall into the low word.
    always_comb begin
        rot_amt  = {instr_imm[11:8], 1'b0};
        rot_pair = {24'h0, instr_imm[7:0], 24'h0, instr_imm[7:0]} >> rot_amt;
        dp_imm   = rot_pair[31:0];
    end
`else
    logic unused_rot;

    assign unused_rot = ^instr_imm[11:8];
    assign dp_imm     = {24'h0, instr_imm[7:0]};
`endif

    // Immediate extension by instruction class.
    always_comb begin
        ext_imm = 32'h0;
        case (imm_src_e'(imm_src))
            IMM_DP:   ext_imm = dp_imm;
            IMM_MEM:  ext_imm = {20'h0, instr_imm[11:0]};
            IMM_BR:   ext_imm = {{6{instr_imm[23]}}, instr_imm, 2'b00};
            IMM_ZERO: ext_imm = 32'h0;
            default:  ext_imm = 32'h0;
        endcase
    end

    alu_core u_alu_core (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .carry_in    (stored_flags[FLAG_C]),
        .overflow_in (stored_flags[FLAG_V]),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags)
    );

    // Flag register: reset wins over flag_write; no same-cycle forwarding to the ALU.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stored_flags <= 4'b0000;
        end else if (flag_write) begin
            stored_flags <= alu_flags;
        end
    end

endmodule

// File: tb/tb_arm_exec_unit.sv
// Scoreboard bench for arm_exec_unit: a driver issues one transaction per
// cycle and queues the reference model's expectation; a monitor on the
// falling edge pops and compares every output.
module tb_arm_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [23:0] instr_imm;
    logic [1:0]  imm_src;
    logic [31:0] ext_imm;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  alu_control;
    logic        flag_write;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [3:0]  stored_flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic [3:0]  stored;
        logic [31:0] p4;
        logic [31:0] p8;
        logic [31:0] ext;
    } exp_t;

    exp_t        sb_q[$];
    logic [3:0]  model_flags;
    int          checks   = 0;
    int          failures = 0;

    arm_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_plus8     (pc_plus8),
        .instr_imm    (instr_imm),
        .imm_src      (imm_src),
        .ext_imm      (ext_imm),
        .src_a        (src_a),
        .src_b        (src_b),
        .alu_control  (alu_control),
        .flag_write   (flag_write),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .stored_flags (stored_flags)
    );

    always #5 clk = ~clk;

    // Reference ALU: true-integer arithmetic on 64-bit values.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] sf,
                                    output logic [31:0] res, output logic [3:0] fl);
        longint ua, ub, sa, sb, ci, bi, u, s;
        logic   c, v, arith;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'({{32{a[31]}}, a});
        sb = longint'({{32{b[31]}}, b});
        ci = sf[1] ? 64'sd1 : 64'sd0;
        bi = 64'sd1 - ci;
        c = sf[1];
        v = sf[0];
        u = 0;
        s = 0;
        res = 32'h0;
        arith = 1'b1;
        case (op)
            4'h4, 4'hB: begin u = ua + ub;      s = sa + sb;      c = (u > 64'sd4294967295); end
            4'h5:       begin u = ua + ub + ci; s = sa + sb + ci; c = (u > 64'sd4294967295); end
            4'h2, 4'hA: begin u = ua - ub;      s = sa - sb;      c = (u >= 0); end
            4'h6:       begin u = ua - ub - bi; s = sa - sb - bi; c = (u >= 0); end
            4'h3:       begin u = ub - ua;      s = sb - sa;      c = (u >= 0); end
            4'h7:       begin u = ub - ua - bi; s = sb - sa - bi; c = (u >= 0); end
            default:    arith = 1'b0;
        endcase
        if (arith) begin
            res = u[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            case (op)
                4'h0, 4'h8: res = a & b;
                4'h1, 4'h9: res = a ^ b;
                4'hC:       res = a | b;
                4'hD:       res = b;
                4'hE:       res = a & ~b;
                default:    res = ~b;
            endcase
        end
        fl = {res[31], res == 32'h0, c, v};
    endfunction

    function automatic logic [31:0] ref_ext(input logic [1:0] isrc, input logic [23:0] imm);
        longint      off;
        logic [31:0] val;
        int          r;
        case (isrc)
            2'b00: begin
                val = {24'h0, imm[7:0]};
`ifdef ROT_IMM_EN
                r = 2 * int'(imm[11:8]);
                if (r != 0) val = (val >> r) | (val << (32 - r));
`else
                r = 0;
`endif
                ref_ext = val;
            end
            2'b01: ref_ext = {20'h0, imm[11:0]};
            2'b10: begin
                off = longint'({{40{imm[23]}}, imm}) * 4;
                ref_ext = off[31:0];
            end
            default: ref_ext = 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one transaction, queue its expectation, then advance one clock.
    task automatic issue(input logic rst_n, input logic fw, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] isrc, input logic [23:0] imm,
                         input logic [31:0] p);
        exp_t e;
        reset       = rst_n;
        flag_write  = fw;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        imm_src     = isrc;
        instr_imm   = imm;
        pc          = p;
        ref_alu(op, a, b, model_flags, e.res, e.flags);
        e.stored = model_flags;
        e.p4     = p + 32'd4;
        e.p8     = p + 32'd8;
        e.ext    = ref_ext(isrc, imm);
        sb_q.push_back(e);
        @(posedge clk);
        if (!rst_n) model_flags = 4'b0000;
        else if (fw) model_flags = e.flags;
        #1;
    endtask

    // Monitor: compare every output of the transaction presented this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("alu_result",   alu_result,           e.res);
            check("alu_flags",    {28'h0, alu_flags},    {28'h0, e.flags});
            check("stored_flags", {28'h0, stored_flags}, {28'h0, e.stored});
            check("pc_plus4",     pc_plus4,             e.p4);
            check("pc_plus8",     pc_plus8,             e.p8);
            check("ext_imm",      ext_imm,              e.ext);
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flag_write = 1'b1; alu_control = 4'h0; src_a = 32'h0; src_b = 32'h0;
        imm_src = 2'b11; instr_imm = 24'h0; pc = 32'h0;
        model_flags = 4'b0000;
        @(posedge clk);
        #1;

        // Directed scenarios.
        issue(1'b1, 1'b1, 4'h4, 32'hFFFF_FFFF, 32'h1, 2'b11, 24'h0, 32'h0);
        issue(1'b1, 1'b0, 4'h5, 32'h2, 32'h3, 2'b11, 24'h0, 32'h0);
        issue(1'b0, 1'b1, 4'h4, 32'hFFFF_FFFF, 32'h1, 2'b11, 24'h0, 32'h100);
        issue(1'b1, 1'b0, 4'h5, 32'h2, 32'h3, 2'b11, 24'h0, 32'h100);
        issue(1'b1, 1'b0, 4'h6, 32'd10, 32'd3, 2'b11, 24'h0, 32'h0);
        issue(1'b1, 1'b1, 4'h3, 32'd3, 32'd10, 2'b11, 24'h0, 32'h0);
        issue(1'b1, 1'b0, 4'h2, 32'd5, 32'd5, 2'b11, 24'h0, 32'h0);
        issue(1'b1, 1'b1, 4'h4, 32'h7FFF_FFFF, 32'h1, 2'b11, 24'h0, 32'hFFFF_FFFC);
        issue(1'b1, 1'b0, 4'hD, 32'h0, 32'h0, 2'b10, 24'hFFFFFE, 32'h0);
        issue(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 2'b01, 24'h000ABC, 32'h0);
        issue(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 2'b11, 24'hFFFFFF, 32'h0);
        issue(1'b1, 1'b0, 4'hC, 32'h0, 32'h0, 2'b00, 24'h0004FF, 32'h0);
        issue(1'b1, 1'b1, 4'h5, 32'hFFFF_FFFF, 32'h0, 2'b00, 24'h000F01, 32'h0);
        issue(1'b1, 1'b1, 4'h5, 32'h1, 32'h1, 2'b00, 24'h000A55, 32'h0);

        // Randomized traffic with corner-biased operands and occasional reset.
        for (int i = 0; i < 400; i++) begin
            issue(($urandom_range(0, 15) != 0), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                  2'($urandom_range(0, 3)), 24'($urandom), pick_operand());
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
